// File: rtl/mproc_pkg.sv
// Shared definitions for the MPROC control sequencer: opcodes, ALU ops,
// FSM states, instruction field positions and the decoded control bundle.
package mproc_pkg;

   typedef enum logic [2:0] {
      OPC_ADD = 3'b000,
      OPC_SUB = 3'b001,
      OPC_AND = 3'b010,
      OPC_OR  = 3'b011,
      OPC_LDI = 3'b100,
      OPC_JMP = 3'b101,
      OPC_JC  = 3'b110,
      OPC_HLT = 3'b111
   } opcode_t;

   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_SUB = 2'b01;
   localparam logic [1:0] ALU_AND = 2'b10;
   localparam logic [1:0] ALU_OR  = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_DECODE,
      ST_EXEC,
      ST_HALT
   } state_t;

   localparam int OPC_MSB = 15;
   localparam int OPC_LSB = 13;
   localparam int RD_MSB  = 12;
   localparam int RD_LSB  = 10;
   localparam int RA_MSB  = 9;
   localparam int RA_LSB  = 7;
   localparam int RB_MSB  = 6;
   localparam int RB_LSB  = 4;
   localparam int TGT_MSB = 12;

   typedef struct packed {
      logic        sel;
      logic        wr_req;
      logic [1:0]  op;
      logic [2:0]  rd_addr_a;
      logic [2:0]  rd_addr_b;
      logic [2:0]  wr_addr;
      logic [15:0] imm;
      logic        is_jmp;
      logic        is_jc;
      logic        is_hlt;
   } ctrl_t;

   function automatic logic [15:0] jump_target(input logic [15:0] ir);
      return {3'b000, ir[TGT_MSB:0]};
   endfunction

endpackage

// File: rtl/mproc_ctrl_if.sv
// Bundle between the sequencer, instruction memory and the reg_alu datapath.
// master = sequencer side, slave = memory/datapath/host side.
interface mproc_ctrl_if;
   logic        run;
   logic        halted;
   logic        busy;
   logic [15:0] imem_addr;
   logic [15:0] imem_data;
   logic        cout;
   logic        sel;
   logic        wr;
   logic [1:0]  op;
   logic [2:0]  rd_addr_a;
   logic [2:0]  rd_addr_b;
   logic [2:0]  wr_addr;
   logic [15:0] d_in;

   modport master (
      input  run, imem_data, cout,
      output imem_addr, sel, wr, op, rd_addr_a, rd_addr_b, wr_addr, d_in,
             halted, busy
   );

   modport slave (
      output run, imem_data, cout,
      input  imem_addr, sel, wr, op, rd_addr_a, rd_addr_b, wr_addr, d_in,
             halted, busy
   );
endinterface

// File: rtl/mproc_decode.sv
// Pure combinational instruction decoder: IR -> control bundle.
module mproc_decode
   import mproc_pkg::*;
#(
   parameter int IMM_WIDTH = 10
) (
   input  logic [15:0] ir,
   output ctrl_t       ctrl
);

   opcode_t opc;
   assign opc = opcode_t'(ir[OPC_MSB:OPC_LSB]);

   always_comb begin
      // NOTE: every field gets a default before the case so no path can
      // leave it unassigned, which would infer a latch.
      ctrl           = '0;
      ctrl.rd_addr_a = ir[RA_MSB:RA_LSB];
      ctrl.rd_addr_b = ir[RB_MSB:RB_LSB];
      ctrl.wr_addr   = ir[RD_MSB:RD_LSB];
      case (opc)
         OPC_ADD, OPC_SUB, OPC_AND, OPC_OR: begin
            ctrl.sel    = 1'b1;
            ctrl.wr_req = 1'b1;
            // The low opcode bits are the ALU op encoding
            ctrl.op     = ir[OPC_LSB+1:OPC_LSB];
         end
         OPC_LDI: begin
            ctrl.wr_req = 1'b1;
            ctrl.imm    = 16'(ir[IMM_WIDTH-1:0]);
         end
         OPC_JMP: ctrl.is_jmp = 1'b1;
         OPC_JC:  ctrl.is_jc  = 1'b1;
         OPC_HLT: ctrl.is_hlt = 1'b1;
      endcase
   end

endmodule

// File: rtl/mproc_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC sequencer driving the reg_alu datapath.
// Optional macro MPROC_CTRL_ICOUNT_EN adds the icount executed-instruction counter.
module mproc_ctrl
   import mproc_pkg::*;
#(
   parameter logic [15:0] RESET_PC  = 16'h0000,
   parameter int          IMM_WIDTH = 10
) (
   input  logic             clk,
   input  logic             reset,
   mproc_ctrl_if.master     bus
`ifdef MPROC_CTRL_ICOUNT_EN
   ,
   output logic [15:0]      icount
`endif
);

   state_t      state, state_n;
   logic [15:0] pc, pc_n;
   logic [15:0] ir, ir_n;
   logic        carry_flag, carry_flag_n;
   logic        carry_pend, carry_pend_n;
   ctrl_t       ctrl;

   mproc_decode #(.IMM_WIDTH(IMM_WIDTH)) u_decode (
      .ir   (ir),
      .ctrl (ctrl)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= ST_IDLE;
         pc         <= RESET_PC;
         ir         <= '0;
         carry_flag <= 1'b0;
         carry_pend <= 1'b0;
      end else begin
         // NOTE: non-blocking so every register samples pre-edge values.
         state      <= state_n;
         pc         <= pc_n;
         ir         <= ir_n;
         carry_flag <= carry_flag_n;
         carry_pend <= carry_pend_n;
      end
   end

   // Addresses follow IR in every state; reset clears IR so they read 0.
   assign bus.imem_addr = pc;
   assign bus.rd_addr_a = ctrl.rd_addr_a;
   assign bus.rd_addr_b = ctrl.rd_addr_b;
   assign bus.wr_addr   = ctrl.wr_addr;

   always_comb begin
      state_n      = state;
      pc_n         = pc;
      ir_n         = ir;
      carry_flag_n = carry_flag;
      carry_pend_n = carry_pend;
      bus.sel      = 1'b0;
      bus.wr       = 1'b0;
      bus.op       = ALU_ADD;
      bus.d_in     = '0;
      bus.busy     = 1'b0;
      bus.halted   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (bus.run) state_n = ST_FETCH;
         end
         ST_FETCH: begin
            bus.busy = 1'b1;
            // Datapath carry is registered on the edge ending the ALU EXEC,
            // so it is first valid here.
            if (carry_pend) begin
               carry_flag_n = bus.cout;
               carry_pend_n = 1'b0;
            end
            state_n = ST_DECODE;
         end
         ST_DECODE: begin
            bus.busy = 1'b1;
            ir_n     = bus.imem_data;
            state_n  = ST_EXEC;
         end
         ST_EXEC: begin
            bus.busy = 1'b1;
            bus.sel  = ctrl.sel;
            bus.wr   = ctrl.wr_req;
            bus.op   = ctrl.op;
            bus.d_in = ctrl.imm;
            if (ctrl.sel) carry_pend_n = 1'b1;
            if (ctrl.is_hlt) begin
               state_n = ST_HALT;
            end else begin
               state_n = ST_FETCH;
               if (ctrl.is_jmp || (ctrl.is_jc && carry_flag))
                  pc_n = jump_target(ir);
               else
                  pc_n = pc + 16'd1;
            end
         end
         ST_HALT: begin
            bus.halted = 1'b1;
         end
         default: state_n = ST_IDLE;
      endcase
   end

`ifdef MPROC_CTRL_ICOUNT_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                  icount <= '0;
      else if (state == ST_EXEC)  icount <= icount + 16'd1;
   end
`endif

endmodule

// File: tb/tb_mproc_ctrl.sv
// Self-checking bench for mproc_ctrl: directed scenarios plus random programs
// checked against an instruction-level reference model.
module tb_mproc_ctrl;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   mproc_ctrl_if bus ();
   mproc_ctrl_if wbus ();

   logic [15:0] rom [logic [15:0]];

`ifdef MPROC_CTRL_ICOUNT_EN
   logic [15:0] icount;
   logic [15:0] wicount;
`endif

   mproc_ctrl #(.RESET_PC(16'h0000), .IMM_WIDTH(10)) u_dut (
      .clk    (clk),
      .reset  (reset),
      .bus    (bus)
`ifdef MPROC_CTRL_ICOUNT_EN
      ,
      .icount (icount)
`endif
   );

   // Second instance starts near the top of the address space for wrap checks
   mproc_ctrl #(.RESET_PC(16'hFFFE), .IMM_WIDTH(10)) u_dut_wrap (
      .clk    (clk),
      .reset  (reset),
      .bus    (wbus)
`ifdef MPROC_CTRL_ICOUNT_EN
      ,
      .icount (wicount)
`endif
   );

   // Unwritten locations read as HLT
   function automatic logic [15:0] rom_rd(input logic [15:0] a);
      if (rom.exists(a)) return rom[a];
      return 16'hE000;
   endfunction

   // Synchronous ROM: data one cycle after address
   always @(posedge clk) begin
      bus.imem_data  <= rom_rd(bus.imem_addr);
      wbus.imem_data <= rom_rd(wbus.imem_addr);
   end

   function automatic logic [28:0] ctl();
      return {bus.wr, bus.sel, bus.op, bus.rd_addr_a, bus.rd_addr_b,
              bus.wr_addr, bus.d_in};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset     = 1'b1;
      bus.run   = 1'b0;
      bus.cout  = 1'b0;
      wbus.run  = 1'b0;
      wbus.cout = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   // Runs the program in rom from PC 0 for up to n instructions (stops at HLT).
   // cm: 0/1 forces cout during FETCH, 2 randomizes it; cout is random elsewhere.
   task automatic run_prog(input int n, input int cm, input string tag,
                           output logic [15:0] final_pc);
      logic [15:0] pc, ins, nxt, e_d;
      logic [2:0]  opc;
      logic [28:0] exp_v;
      logic        flag, pend, c;
      int          n_exec;
      pc = 16'h0000; flag = 1'b0; pend = 1'b0; n_exec = 0;
      bus.run = 1'b1;
      tick();
      bus.run = 1'b0;
      for (int k = 0; k < n; k++) begin
         c = (cm == 2) ? 1'($urandom_range(0, 1)) : 1'(cm);
         bus.cout = c;
         if (pend) begin flag = c; pend = 1'b0; end
         n_checks++;
         if ({bus.imem_addr, bus.busy, bus.halted, bus.wr, bus.sel, bus.op, bus.d_in}
             !== {pc, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 16'h0000}) begin
            n_errors++;
            $display("FAIL %s fetch step %0d: got addr=%h busy=%b halted=%b wr=%b sel=%b op=%b d_in=%h, want addr=%h busy=1 halted=0 wr=0 sel=0 op=00 d_in=0000",
                     tag, k, bus.imem_addr, bus.busy, bus.halted, bus.wr, bus.sel, bus.op, bus.d_in, pc);
         end
         tick();
         bus.cout = 1'($urandom_range(0, 1));
         n_checks++;
         if ({bus.busy, bus.halted, bus.wr, bus.sel, bus.op, bus.d_in}
             !== {1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 16'h0000}) begin
            n_errors++;
            $display("FAIL %s decode step %0d: got busy=%b halted=%b wr=%b sel=%b op=%b d_in=%h, want busy=1 halted=0 wr=0 sel=0 op=00 d_in=0000",
                     tag, k, bus.busy, bus.halted, bus.wr, bus.sel, bus.op, bus.d_in);
         end
         tick();
         bus.cout = 1'($urandom_range(0, 1));
         ins = rom_rd(pc);
         opc = ins[15:13];
         e_d = (opc == 3'd4) ? {6'd0, ins[9:0]} : 16'h0000;
         exp_v = {(opc <= 3'd4), (opc < 3'd4), (opc < 3'd4) ? opc[1:0] : 2'b00,
                  ins[9:7], ins[6:4], ins[12:10], e_d};
         n_checks++;
         if ({ctl(), bus.busy} !== {exp_v, 1'b1}) begin
            n_errors++;
            $display("FAIL %s exec step %0d ins=%h: got {wr,sel,op,ra,rb,wa,d_in,busy}=%h, want %h",
                     tag, k, ins, {ctl(), bus.busy}, {exp_v, 1'b1});
         end
         n_exec++;
         case (opc)
            3'd5:    nxt = {3'b000, ins[12:0]};
            3'd6:    nxt = flag ? {3'b000, ins[12:0]} : pc + 16'd1;
            3'd7:    nxt = pc;
            default: nxt = pc + 16'd1;
         endcase
         if (opc < 3'd4) pend = 1'b1;
         pc = nxt;
         tick();
         if (opc == 3'd7) begin
            n_checks++;
            if ({bus.halted, bus.busy, bus.wr, bus.imem_addr} !== {1'b1, 1'b0, 1'b0, pc}) begin
               n_errors++;
               $display("FAIL %s halt entry: got halted=%b busy=%b wr=%b addr=%h, want halted=1 busy=0 wr=0 addr=%h",
                        tag, bus.halted, bus.busy, bus.wr, bus.imem_addr, pc);
            end
            break;
         end
      end
`ifdef MPROC_CTRL_ICOUNT_EN
      n_checks++;
      if (icount !== 16'(n_exec)) begin
         n_errors++;
         $display("FAIL %s icount: got %0d, want %0d", tag, icount, n_exec);
      end
`endif
      final_pc = pc;
   endtask

   task automatic test_reset();
      do_reset();
      repeat (3) begin
         n_checks++;
         if ({ctl(), bus.halted, bus.busy, bus.imem_addr} !== 47'd0) begin
            n_errors++;
            $display("FAIL reset_idle: got {ctl,halted,busy,addr}=%h, want 0",
                     {ctl(), bus.halted, bus.busy, bus.imem_addr});
         end
         tick();
      end
      n_checks++;
      if (wbus.imem_addr !== 16'hFFFE) begin
         n_errors++;
         $display("FAIL reset_pc_param: got %h, want fffe", wbus.imem_addr);
      end
`ifdef MPROC_CTRL_ICOUNT_EN
      n_checks++;
      if (icount !== 16'd0) begin
         n_errors++;
         $display("FAIL reset_icount: got %0d, want 0", icount);
      end
`endif
   endtask

   task automatic test_ldi_add();
      logic [15:0] fpc;
      rom.delete();
      rom[16'd0] = 16'h8405;  // LDI r1,#5
      rom[16'd1] = 16'h0890;  // ADD r2,r1,r1
      rom[16'd2] = 16'h6CA0;  // OR  r3,r1,r2
      rom[16'd3] = 16'h9FFF;  // LDI r7,#3FF
      rom[16'd4] = 16'hE000;  // HLT
      do_reset();
      run_prog(10, 2, "ldi_add", fpc);
      n_checks++;
      if (fpc !== 16'd4 || bus.imem_addr !== 16'd4) begin
         n_errors++;
         $display("FAIL ldi_add final pc: got %h, want 0004", bus.imem_addr);
      end
   endtask

   task automatic test_jc();
      logic [15:0] fpc;
      rom.delete();
      rom[16'd0]  = 16'h8405;  // LDI r1,#5
      rom[16'd1]  = 16'h0890;  // ADD r2,r1,r1
      rom[16'd2]  = 16'hC040;  // JC 0x40
      rom[16'd3]  = 16'hE000;
      rom[16'h40] = 16'hE000;
      do_reset();
      run_prog(10, 1, "jc_taken", fpc);
      n_checks++;
      if (bus.imem_addr !== 16'h0040) begin
         n_errors++;
         $display("FAIL jc_taken pc: got %h, want 0040", bus.imem_addr);
      end
      do_reset();
      run_prog(10, 0, "jc_not_taken", fpc);
      n_checks++;
      if (bus.imem_addr !== 16'h0003) begin
         n_errors++;
         $display("FAIL jc_not_taken pc: got %h, want 0003", bus.imem_addr);
      end
   endtask

   task automatic test_jmp_halt();
      logic [15:0] fpc;
      rom.delete();
      rom[16'd0] = 16'hBFFF;  // JMP 0x1FFF
      do_reset();
      run_prog(10, 2, "jmp", fpc);
      n_checks++;
      if (bus.imem_addr !== 16'h1FFF) begin
         n_errors++;
         $display("FAIL jmp pc: got %h, want 1fff", bus.imem_addr);
      end
      for (int i = 0; i < 6; i++) begin
         bus.run = ~bus.run;
         tick();
         n_checks++;
         if ({bus.halted, bus.busy, bus.wr, bus.imem_addr} !== {3'b100, 16'h1FFF}) begin
            n_errors++;
            $display("FAIL halt_hold cycle %0d: got halted=%b busy=%b wr=%b addr=%h, want 1 0 0 1fff",
                     i, bus.halted, bus.busy, bus.wr, bus.imem_addr);
         end
      end
      bus.run = 1'b0;
      reset = 1'b1;
      #1;
      n_checks++;
      if ({bus.halted, bus.busy, bus.imem_addr} !== 18'd0) begin
         n_errors++;
         $display("FAIL halt_reset: got halted=%b busy=%b addr=%h, want 0 0 0000",
                  bus.halted, bus.busy, bus.imem_addr);
      end
      do_reset();
   endtask

   task automatic test_reset_mid_exec();
      rom.delete();
      rom[16'd0] = 16'h8405;
      rom[16'd1] = 16'h0890;
      do_reset();
      bus.run = 1'b1;
      tick();
      bus.run = 1'b0;
      repeat (5) tick();
      n_checks++;
      if ({bus.wr, bus.sel, bus.wr_addr} !== {2'b11, 3'd2}) begin
         n_errors++;
         $display("FAIL mid_exec precondition: got wr=%b sel=%b wa=%0d, want 1 1 2",
                  bus.wr, bus.sel, bus.wr_addr);
      end
      #2;
      reset = 1'b1;
      #1;
      n_checks++;
      if ({ctl(), bus.halted, bus.busy, bus.imem_addr} !== 47'd0) begin
         n_errors++;
         $display("FAIL mid_exec abort: got {ctl,halted,busy,addr}=%h, want 0",
                  {ctl(), bus.halted, bus.busy, bus.imem_addr});
      end
      @(posedge clk);
      #1;
      n_checks++;
      if (bus.wr !== 1'b0) begin
         n_errors++;
         $display("FAIL mid_exec no_write: got wr=%b, want 0", bus.wr);
      end
      do_reset();
   endtask

   task automatic test_wrap();
      rom.delete();
      rom[16'hFFFE] = 16'h8C07;  // LDI r3,#7
      rom[16'hFFFF] = 16'h6CA0;  // OR r3,r1,r2
      rom[16'h0000] = 16'hE000;
      do_reset();
      wbus.run = 1'b1;
      tick();
      wbus.run = 1'b0;
      repeat (3) tick();
      n_checks++;
      if (wbus.imem_addr !== 16'hFFFF) begin
         n_errors++;
         $display("FAIL wrap step1 pc: got %h, want ffff", wbus.imem_addr);
      end
      repeat (2) tick();
      n_checks++;
      if ({wbus.wr, wbus.sel, wbus.op, wbus.wr_addr} !== {2'b11, 2'b11, 3'd3}) begin
         n_errors++;
         $display("FAIL wrap or_exec: got wr=%b sel=%b op=%b wa=%0d, want 1 1 11 3",
                  wbus.wr, wbus.sel, wbus.op, wbus.wr_addr);
      end
      tick();
      n_checks++;
      if (wbus.imem_addr !== 16'h0000) begin
         n_errors++;
         $display("FAIL wrap pc: got %h, want 0000", wbus.imem_addr);
      end
      repeat (3) tick();
      n_checks++;
      if ({wbus.halted, wbus.busy} !== 2'b10) begin
         n_errors++;
         $display("FAIL wrap halt: got halted=%b busy=%b, want 1 0", wbus.halted, wbus.busy);
      end
   endtask

   task automatic test_random();
      logic [15:0] fpc, ins;
      for (int r = 0; r < 15; r++) begin
         rom.delete();
         for (int a = 0; a < 64; a++) begin
            ins = 16'($urandom);
            if (ins[15:13] == 3'd5 || ins[15:13] == 3'd6)
               ins = {ins[15:13], 7'd0, ins[5:0]};
            rom[16'(a)] = ins;
         end
         do_reset();
         run_prog(40, 2, "random", fpc);
      end
   endtask

   initial begin
      test_reset();
      test_ldi_add();
      test_jc();
      test_jmp_halt();
      test_reset_mid_exec();
      test_wrap();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
